// File: rtl/calc_pkg.sv
// ---------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the sequential signed-magnitude calculator:
// operation codes, the controller state encoding and a small helper that
// suppresses negative zero.
// ---------------------------------------------------------------------------
package calc_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDSUB = 3'd1,
        ST_MUL    = 3'd2,
        ST_DIV    = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // A zero magnitude is always reported as positive.
    function automatic logic nz_sign(input logic sign, input logic is_zero);
        return sign & ~is_zero;
    endfunction

endpackage

// File: rtl/calc_iter_unit.sv
// ---------------------------------------------------------------------------
// calc_iter_unit
// Iterative unsigned datapath: shift-add multiply (one partial product per
// cycle) and restoring divide (one quotient bit per cycle). Operands are
// loaded on i_load; each i_run cycle performs one iteration. o_q / o_r show
// the result *after* the iteration currently being performed, so the caller
// can capture the final result on the same edge as the last iteration.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   i_load       : load operands i_a / i_b and clear accumulators/counter
//   i_run        : perform one iteration this cycle
//   i_div        : 1 = divide iteration, 0 = multiply iteration
//   i_a, i_b     : operand magnitudes (multiplicand/dividend, multiplier/divisor)
//   o_q, o_r     : product or quotient, remainder (0 for multiply)
//   o_last       : current iteration is the final (WIDTH-th) one
// ---------------------------------------------------------------------------
module calc_iter_unit #(
    parameter int WIDTH = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               i_load,
    input  logic               i_run,
    input  logic               i_div,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic [2*WIDTH-1:0] o_q,
    output logic [WIDTH-1:0]   o_r,
    output logic               o_last
);

    // Counter must be able to reach WIDTH after the last increment.
    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_mplier;
    logic [WIDTH-1:0]   r_dvd;
    logic [WIDTH-1:0]   r_dvsr;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;

    logic [2*WIDTH-1:0] w_acc_nxt;
    logic [WIDTH:0]     w_rem_sh;
    logic               w_fits;
    logic [WIDTH-1:0]   w_rem_nxt;
    logic [WIDTH-1:0]   w_quo_nxt;

    // One combinational step of each algorithm
    always_comb begin
        w_acc_nxt = r_acc;
        if (r_mplier[0]) begin
            w_acc_nxt = r_acc + r_mcand;
        end else begin
            w_acc_nxt = r_acc;
        end
        // Remainder is always below the divisor, so the shifted value fits WIDTH+1 bits.
        w_rem_sh = {r_rem, r_dvd[WIDTH-1]};
        w_fits   = (w_rem_sh >= {1'b0, r_dvsr});
        if (w_fits) begin
            w_rem_nxt = WIDTH'(w_rem_sh - {1'b0, r_dvsr});
        end else begin
            w_rem_nxt = WIDTH'(w_rem_sh);
        end
        w_quo_nxt = {r_quo[WIDTH-2:0], w_fits};
    end

    // Operand load on accept, then one iteration per run cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt    <= {CW{1'b0}};
            r_mcand  <= {(2*WIDTH){1'b0}};
            r_acc    <= {(2*WIDTH){1'b0}};
            r_mplier <= {WIDTH{1'b0}};
            r_dvd    <= {WIDTH{1'b0}};
            r_dvsr   <= {WIDTH{1'b0}};
            r_rem    <= {WIDTH{1'b0}};
            r_quo    <= {WIDTH{1'b0}};
        end else if (i_load) begin
            r_cnt    <= {CW{1'b0}};
            r_mcand  <= {{WIDTH{1'b0}}, i_a};
            r_acc    <= {(2*WIDTH){1'b0}};
            r_mplier <= i_b;
            r_dvd    <= i_a;
            r_dvsr   <= i_b;
            r_rem    <= {WIDTH{1'b0}};
            r_quo    <= {WIDTH{1'b0}};
        end else if (i_run) begin
            r_cnt <= r_cnt + CW'(1);
            if (i_div) begin
                r_rem <= w_rem_nxt;
                r_quo <= w_quo_nxt;
                r_dvd <= {r_dvd[WIDTH-2:0], 1'b0};
            end else begin
                r_acc    <= w_acc_nxt;
                r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
                r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
            end
        end
    end

    // Present the post-iteration result of the selected algorithm
    always_comb begin
        if (i_div) begin
            o_q = {{WIDTH{1'b0}}, w_quo_nxt};
            o_r = w_rem_nxt;
        end else begin
            o_q = w_acc_nxt;
            o_r = {WIDTH{1'b0}};
        end
    end

    assign o_last = (r_cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/calc_seq_engine.sv
// ---------------------------------------------------------------------------
// calc_seq_engine
// Sequential signed-magnitude calculator: add, subtract, multiply, divide.
// Add/subtract finishes in one working cycle; multiply and divide take WIDTH
// cycles in calc_iter_unit. Results are registered on entry to DONE and held.
// Ports:
//   clock, reset     : system clock, synchronous active-high reset
//   start, op        : begin operation (accepted in IDLE only), op select
//   signA, A         : sign (1 = negative) and magnitude of operand A
//   signB, B         : sign (1 = negative) and magnitude of operand B
//   busy, done       : operation in progress, one-cycle result-valid pulse
//   Q, signQ, R      : result magnitude, its sign, divide remainder
//   div_zero         : last result came from a divide by zero
// ---------------------------------------------------------------------------
module calc_seq_engine
    import calc_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic               signA,
    input  logic               signB,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] Q,
    output logic               signQ,
    output logic [WIDTH-1:0]   R,
    output logic               div_zero
);

    state_t             r_state;
    state_t             w_next;
    logic [1:0]         r_op;
    logic               r_sa;
    logic               r_sb;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_busy;
    logic               r_done;
    logic [2*WIDTH-1:0] r_q;
    logic               r_sq;
    logic [WIDTH-1:0]   r_r;
    logic               r_dz;

    logic               w_accept;
    logic               w_run;
    logic               w_is_div;
    logic               w_capture;
    logic [2*WIDTH-1:0] w_iter_q;
    logic [WIDTH-1:0]   w_iter_r;
    logic               w_iter_last;
    logic               w_sb_eff;
    logic [2*WIDTH-1:0] w_as_mag;
    logic               w_as_sign;
    logic [2*WIDTH-1:0] w_res_q;
    logic               w_res_sq;
    logic [WIDTH-1:0]   w_res_r;
    logic               w_res_dz;

    assign w_accept  = (r_state == ST_IDLE) && start;
    assign w_run     = (r_state == ST_MUL) || (r_state == ST_DIV);
    assign w_is_div  = (r_state == ST_DIV);
    assign w_capture = (w_next == ST_DONE) && (r_state != ST_DONE);

    calc_iter_unit #(.WIDTH(WIDTH)) u_iter (
        .clock  (clock),
        .reset  (reset),
        .i_load (w_accept),
        .i_run  (w_run),
        .i_div  (w_is_div),
        .i_a    (A),
        .i_b    (B),
        .o_q    (w_iter_q),
        .o_r    (w_iter_r),
        .o_last (w_iter_last)
    );

    // Controller state register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state selection
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    case (op)
                        OP_ADD, OP_SUB: w_next = ST_ADDSUB;
                        OP_MUL:         w_next = ST_MUL;
                        OP_DIV:         w_next = (B == {WIDTH{1'b0}}) ? ST_DONE : ST_DIV;
                        default:        w_next = ST_IDLE;
                    endcase
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_ADDSUB: w_next = ST_DONE;
            ST_MUL, ST_DIV: begin
                if (w_iter_last) begin
                    w_next = ST_DONE;
                end else begin
                    w_next = r_state;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Operand capture on the accepting edge; later input changes are ignored
    always_ff @(posedge clock) begin
        if (reset) begin
            r_op <= OP_ADD;
            r_sa <= 1'b0;
            r_sb <= 1'b0;
            r_a  <= {WIDTH{1'b0}};
            r_b  <= {WIDTH{1'b0}};
        end else if (w_accept) begin
            r_op <= op;
            r_sa <= signA;
            r_sb <= signB;
            r_a  <= A;
            r_b  <= B;
        end
    end

    // Signed-magnitude add; subtract is add with B's sign flipped
    always_comb begin
        w_sb_eff  = r_sb ^ (r_op == OP_SUB);
        w_as_mag  = {(2*WIDTH){1'b0}};
        w_as_sign = 1'b0;
        if (r_sa == w_sb_eff) begin
            w_as_mag  = {{WIDTH{1'b0}}, r_a} + {{WIDTH{1'b0}}, r_b};
            w_as_sign = r_sa;
        end else if (r_a >= r_b) begin
            w_as_mag  = {{WIDTH{1'b0}}, r_a - r_b};
            w_as_sign = r_sa;
        end else begin
            w_as_mag  = {{WIDTH{1'b0}}, r_b - r_a};
            w_as_sign = w_sb_eff;
        end
    end

    // Result to capture; the IDLE->DONE path is only taken on divide by zero
    always_comb begin
        w_res_q  = {(2*WIDTH){1'b0}};
        w_res_sq = 1'b0;
        w_res_r  = {WIDTH{1'b0}};
        w_res_dz = 1'b0;
        case (r_state)
            ST_ADDSUB: begin
                w_res_q  = w_as_mag;
                w_res_sq = nz_sign(w_as_sign, w_as_mag == {(2*WIDTH){1'b0}});
            end
            ST_MUL, ST_DIV: begin
                w_res_q  = w_iter_q;
                w_res_r  = w_iter_r;
                w_res_sq = nz_sign(r_sa ^ r_sb, w_iter_q == {(2*WIDTH){1'b0}});
            end
            default: begin
                w_res_dz = 1'b1;
            end
        endcase
    end

    // Registered status and result outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_q    <= {(2*WIDTH){1'b0}};
            r_sq   <= 1'b0;
            r_r    <= {WIDTH{1'b0}};
            r_dz   <= 1'b0;
        end else begin
            r_busy <= (w_next != ST_IDLE);
            r_done <= (w_next == ST_DONE);
            if (w_capture) begin
                r_q  <= w_res_q;
                r_sq <= w_res_sq;
                r_r  <= w_res_r;
                r_dz <= w_res_dz;
            end
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign Q        = r_q;
    assign signQ    = r_sq;
    assign R        = r_r;
    assign div_zero = r_dz;

endmodule

// File: tb/tb_calc_seq_engine.sv
// ---------------------------------------------------------------------------
// tb_calc_seq_engine
// Scoreboard bench: the stimulus process pushes the expected result and the
// expected done cycle for every issued operation; a monitor on the falling
// edge pops and compares whenever done is high, and otherwise checks that the
// registered result holds the most recent expected value.
// ---------------------------------------------------------------------------
module tb_calc_seq_engine;

    localparam int WIDTH = 4;
    localparam int QW    = 2 * WIDTH;
    localparam int MAXV  = (1 << WIDTH) - 1;

    logic             clock = 1'b0;
    logic             reset;
    logic             start;
    logic [1:0]       op;
    logic             signA;
    logic             signB;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [QW-1:0]    Q;
    logic             signQ;
    logic [WIDTH-1:0] R;
    logic             div_zero;

    typedef struct {
        logic [QW-1:0]    q;
        logic             sq;
        logic [WIDTH-1:0] r;
        logic             dz;
        int unsigned      due;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        last_e;
    exp_t        mon_e;
    bit          mon_en = 1'b0;
    int unsigned cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;

    calc_seq_engine #(.WIDTH(WIDTH)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .signA    (signA),
        .signB    (signB),
        .A        (A),
        .B        (B),
        .busy     (busy),
        .done     (done),
        .Q        (Q),
        .signQ    (signQ),
        .R        (R),
        .div_zero (div_zero)
    );

    // Free-running clock
    always #5 clock = ~clock;

    // Cycle counter used for latency checks
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Reference: plain signed integer arithmetic on the signed-magnitude operands.
    function automatic exp_t model(input logic [1:0] o, input logic sa, input logic sb,
                                   input int a, input int b);
        exp_t e;
        int   va;
        int   vb;
        int   res;
        e.q   = '0;
        e.sq  = 1'b0;
        e.r   = '0;
        e.dz  = 1'b0;
        e.due = 0;
        va = sa ? -a : a;
        vb = sb ? -b : b;
        case (o)
            2'b00, 2'b01: begin
                if (o == 2'b01) vb = -vb;
                res   = va + vb;
                e.q   = QW'((res < 0) ? -res : res);
                e.sq  = (res < 0);
                e.due = 2;
            end
            2'b10: begin
                res   = a * b;
                e.q   = QW'(res);
                e.sq  = (sa != sb) && (res != 0);
                e.due = WIDTH + 1;
            end
            default: begin
                if (b == 0) begin
                    e.dz  = 1'b1;
                    e.due = 1;
                end else begin
                    e.q   = QW'(a / b);
                    e.r   = WIDTH'(a % b);
                    e.sq  = (sa != sb) && ((a / b) != 0);
                    e.due = WIDTH + 1;
                end
            end
        endcase
        return e;
    endfunction

    // Issue one operation (called #1 after a rising edge), then stir inputs while busy.
    task automatic issue(input logic [1:0] o, input logic sa, input logic sb,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t e;
        int   t = 0;
        while (busy !== 1'b0 && t < 100) begin
            @(posedge clock); #1;
            t++;
        end
        if (t >= 100) begin
            vectors++;
            miscompares++;
            $display("FAIL idle_wait: busy still %b after %0d cycles", busy, t);
        end
        op = o; signA = sa; signB = sb; A = a; B = b; start = 1'b1;
        e = model(o, sa, sb, int'(a), int'(b));
        e.due = e.due + cyc;
        sb_q.push_back(e);
        @(posedge clock); #1;
        start = 1'b0;
        t = 0;
        while (busy === 1'b1 && t < 100) begin
            A     = WIDTH'($urandom_range(0, MAXV));
            B     = WIDTH'($urandom_range(0, MAXV));
            op    = 2'($urandom_range(0, 3));
            signA = 1'($urandom_range(0, 1));
            signB = 1'($urandom_range(0, 1));
            start = 1'($urandom_range(0, 1));
            @(posedge clock); #1;
            start = 1'b0;
            t++;
        end
        if (t >= 100) begin
            vectors++;
            miscompares++;
            $display("FAIL busy_wait: busy stuck after %0d cycles", t);
        end
    endtask

    // Monitor: compare on done, otherwise require the held result
    always @(negedge clock) begin
        if (mon_en) begin
            if (done === 1'b1) begin
                if (sb_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_done: got done=1 required no pending result");
                end else begin
                    mon_e = sb_q.pop_front();
                    check("latency", cyc, mon_e.due);
                    check("Q", 32'(Q), 32'(mon_e.q));
                    check("signQ", 32'(signQ), 32'(mon_e.sq));
                    check("R", 32'(R), 32'(mon_e.r));
                    check("div_zero", 32'(div_zero), 32'(mon_e.dz));
                    last_e = mon_e;
                end
            end else begin
                check("hold_result", 32'({Q, signQ, R, div_zero}),
                      32'({last_e.q, last_e.sq, last_e.r, last_e.dz}));
            end
        end
    end

    // Stimulus
    initial begin
        reset = 1'b1; start = 1'b0; op = 2'b00;
        signA = 1'b0; signB = 1'b0; A = '0; B = '0;
        last_e.q = '0; last_e.sq = 1'b0; last_e.r = '0; last_e.dz = 1'b0; last_e.due = 0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_Q", 32'(Q), 32'd0);
        check("reset_signQ", 32'(signQ), 32'd0);
        check("reset_R", 32'(R), 32'd0);
        check("reset_div_zero", 32'(div_zero), 32'd0);
        reset  = 1'b0;
        mon_en = 1'b1;

        issue(2'b00, 1'b0, 1'b1, 4'd7, 4'd3);
        issue(2'b01, 1'b1, 1'b0, 4'd5, 4'd9);
        issue(2'b00, 1'b0, 1'b1, 4'd6, 4'd6);
        issue(2'b10, 1'b1, 1'b0, 4'd15, 4'd15);
        issue(2'b11, 1'b0, 1'b1, 4'd13, 4'd4);
        issue(2'b11, 1'b0, 1'b0, 4'd9, 4'd0);
        issue(2'b11, 1'b1, 1'b0, 4'd3, 4'd7);
        issue(2'b10, 1'b1, 1'b1, 4'd0, 4'd9);

        for (int n = 0; n < 150; n++) begin
            issue(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  WIDTH'($urandom_range(0, MAXV)), WIDTH'($urandom_range(0, MAXV)));
        end

        // Abort a multiply with reset in its second working cycle.
        op = 2'b10; signA = 1'b1; signB = 1'b0; A = 4'd15; B = 4'd15; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        last_e.q = '0; last_e.sq = 1'b0; last_e.r = '0; last_e.dz = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_Q", 32'(Q), 32'd0);
        issue(2'b10, 1'b0, 1'b0, 4'd3, 4'd3);

        for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(posedge clock);
        #1;
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
